// File: rtl/audio_pkg.sv
// Shared definitions for the audio record/playback path: controller state encoding and
// default memory geometry.
package audio_pkg;

  localparam int unsigned DefAddrW = 16;
  localparam int unsigned DefDataW = 16;

  // StPrefetch is internal; it is reported externally as StPlay.
  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StRecord   = 2'd1,
    StPlay     = 2'd2,
    StPrefetch = 2'd3
  } state_e;

endpackage

// File: rtl/sample_ram.sv
// Synchronous single-port sample memory; read data is registered one cycle after re.
module sample_ram
  import audio_pkg::*;
#(
  parameter int unsigned ADDR_W = DefAddrW,
  parameter int unsigned DATA_W = DefDataW
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/record_playback_ctrl.sv
// Record/playback sequencer: streams ADC samples into an external RAM and replays them
// to the DAC path on codec requests, with optional looping.
module record_playback_ctrl
  import audio_pkg::*;
#(
  parameter int unsigned ADDR_W = DefAddrW,
  parameter int unsigned DATA_W = DefDataW
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sample_end,
  input  logic              sample_req,
  input  logic [DATA_W-1:0] audio_in,
  output logic [DATA_W-1:0] audio_out,
  input  logic              rec_cmd,
  input  logic              play_cmd,
  input  logic              stop_cmd,
  input  logic              loop_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        state,
  output logic [ADDR_W:0]   rec_len,
  output logic              full
);

  localparam logic [ADDR_W:0] LastAddr = {1'b0, {ADDR_W{1'b1}}};

  state_e            st_q, st_d;
  logic              fetch_q, fetch_d;  // 0: issuing read, 1: read data on mem_rdata
  logic              miss_q, miss_d;
  logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]   rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   rec_len_q, rec_len_d;
  logic              full_q, full_d;
  logic [DATA_W-1:0] audio_out_q, audio_out_d;
  logic [ADDR_W:0]   rd_next;
  logic              we_c, re_c, advance, start_rec;

  assign rd_next = rd_ptr_q + 1'b1;

  always_comb begin
    st_d        = st_q;
    fetch_d     = fetch_q;
    miss_d      = miss_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    rec_len_d   = rec_len_q;
    full_d      = full_q;
    audio_out_d = audio_out_q;
    we_c        = 1'b0;
    re_c        = 1'b0;
    advance     = 1'b0;
    start_rec   = 1'b0;

    unique case (st_q)
      StIdle: begin
        if (stop_cmd) begin
          st_d = StIdle;
        end else if (rec_cmd) begin
          start_rec = 1'b1;
        end else if (play_cmd && rec_len_q != '0) begin
          st_d     = StPrefetch;
          rd_ptr_d = '0;
          fetch_d  = 1'b0;
          miss_d   = 1'b0;
        end
      end
      StRecord: begin
        if (sample_end) begin
          we_c      = 1'b1;
          wr_ptr_d  = wr_ptr_q + 1'b1;
          rec_len_d = wr_ptr_q + 1'b1;
          if (wr_ptr_q == LastAddr) begin
            full_d = 1'b1;
            st_d   = StIdle;
          end
        end
        if (stop_cmd) st_d = StIdle;
      end
      StPlay: begin
        if (stop_cmd) begin
          st_d        = StIdle;
          audio_out_d = '0;
        end else if (rec_cmd) begin
          start_rec = 1'b1;
        end else if (sample_req) begin
          advance = 1'b1;
        end
      end
      StPrefetch: begin
        if (stop_cmd) begin
          st_d        = StIdle;
          audio_out_d = '0;
        end else if (rec_cmd) begin
          start_rec = 1'b1;
        end else if (!fetch_q) begin
          re_c    = 1'b1;
          fetch_d = 1'b1;
          if (sample_req) miss_d = 1'b1;
        end else if (miss_q || sample_req) begin
          // Codec already passed this slot: drop the fetched word and skip ahead.
          advance = 1'b1;
        end else begin
          audio_out_d = mem_rdata;
          st_d        = StPlay;
        end
      end
      default: st_d = StIdle;
    endcase

    if (start_rec) begin
      st_d        = StRecord;
      wr_ptr_d    = '0;
      rec_len_d   = '0;
      full_d      = 1'b0;
      audio_out_d = '0;
    end

    if (advance) begin
      fetch_d = 1'b0;
      miss_d  = 1'b0;
      if (rd_next < rec_len_q) begin
        rd_ptr_d = rd_next;
        st_d     = StPrefetch;
      end else if (loop_en) begin
        rd_ptr_d = '0;
        st_d     = StPrefetch;
      end else begin
        rd_ptr_d    = '0;
        st_d        = StIdle;
        audio_out_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st_q        <= StIdle;
      fetch_q     <= 1'b0;
      miss_q      <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      rec_len_q   <= '0;
      full_q      <= 1'b0;
      audio_out_q <= '0;
    end else begin
      st_q        <= st_d;
      fetch_q     <= fetch_d;
      miss_q      <= miss_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      rec_len_q   <= rec_len_d;
      full_q      <= full_d;
      audio_out_q <= audio_out_d;
    end
  end

  // Strobes are gated by reset so an abort never leaks a write into the RAM.
  assign mem_we    = we_c & ~reset;
  assign mem_re    = re_c & ~reset;
  assign mem_addr  = mem_we ? wr_ptr_q[ADDR_W-1:0] :
                     mem_re ? rd_ptr_q[ADDR_W-1:0] : '0;
  assign mem_wdata = mem_we ? audio_in : '0;
  assign audio_out = audio_out_q;
  assign state     = (st_q == StPrefetch) ? StPlay : st_q;
  assign rec_len   = rec_len_q;
  assign full      = full_q;

endmodule

// File: doc/record_playback_ctrl.md
RECORD_PLAYBACK_CTRL -- requirements
Module: record_playback_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, sample-memory address width (depth 2^ADDR_W samples).
REQ-002 SHALL have parameter DATA_W, default 16, audio sample width.
REQ-003 SHALL have port clk  input  1  audio clock (11.2896 MHz domain); sole clock.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port sample_end  input  1  one-cycle strobe: new ADC sample valid on audio_in.
REQ-006 SHALL have port sample_req  input  1  one-cycle strobe: codec takes audio_out this cycle.
REQ-007 SHALL have port audio_in  input  DATA_W  captured ADC sample.
REQ-008 SHALL have port audio_out  output  DATA_W  sample driven to DAC path.
REQ-009 SHALL have ports rec_cmd, play_cmd, stop_cmd  input  1 each  single-cycle debounced command pulses.
REQ-010 SHALL have port loop_en  input  1  restart playback at address 0 on end of recording.
REQ-011 SHALL have ports mem_addr  output  ADDR_W, mem_wdata  output  DATA_W, mem_we  output  1, mem_re  output  1  to a synchronous single-port RAM.
REQ-012 SHALL have port mem_rdata  input  DATA_W  RAM read data, valid exactly 1 cycle after mem_re.
REQ-013 SHALL have ports state  output  2  (IDLE=0, RECORD=1, PLAY=2), rec_len  output  ADDR_W+1  stored sample count, full  output  1  memory exhausted during last recording.

Function
REQ-014 SHALL implement FSM states IDLE, RECORD, PLAY, PREFETCH (PREFETCH reports state=PLAY).
REQ-015 Command priority in the same cycle SHALL be stop_cmd > rec_cmd > play_cmd.
REQ-016 IDLE: rec_cmd -> RECORD with wr_ptr=0, full=0; play_cmd with rec_len>0 -> PREFETCH with rd_ptr=0; play_cmd with rec_len=0 ignored.
REQ-017 RECORD: each sample_end SHALL assert mem_we for exactly that cycle with mem_addr=wr_ptr, mem_wdata=audio_in, then wr_ptr+1.
REQ-018 RECORD SHALL end on stop_cmd or when the write at address 2^ADDR_W-1 completes (then full=1); rec_len SHALL equal samples written; -> IDLE.
REQ-019 stop_cmd coincident with sample_end in RECORD SHALL still write that sample, then exit.
REQ-020 rec_cmd or play_cmd during RECORD SHALL be ignored; rec_cmd during PLAY SHALL abort playback and start RECORD next cycle.
REQ-021 PREFETCH: SHALL assert mem_re with mem_addr=rd_ptr for one cycle, load audio_out from mem_rdata the following cycle, then enter PLAY.
REQ-022 PLAY: on sample_req the current audio_out is consumed; rd_ptr SHALL increment and, if rd_ptr+1<rec_len, -> PREFETCH for the next sample.
REQ-023 On sample_req with rd_ptr+1=rec_len: loop_en=1 -> rd_ptr=0, PREFETCH; loop_en=0 -> IDLE, audio_out=0.
REQ-024 sample_req arriving while in PREFETCH SHALL be counted as a missed sample: audio_out keeps its old value, rd_ptr advances once more after the fetch.
REQ-025 audio_out SHALL be 0 in IDLE and RECORD; mem_we and mem_re SHALL never be asserted in the same cycle.
REQ-026 Pointers SHALL be ADDR_W+1 bits internally; no wrap of wr_ptr past full.

Reset
REQ-027 On reset: state=IDLE, audio_out=0, mem_we=0, mem_re=0, mem_addr=0, mem_wdata=0, rec_len=0, full=0, pointers=0; a reset mid-RECORD discards the recording (rec_len=0).

Structure
REQ-028 State encoding and default ADDR_W/DATA_W SHALL live in shared package audio_pkg.
REQ-029 The RAM SHALL be a separate sub-module sample_ram (sync single-port, 1-cycle read), instantiated beside, not inside, this block.

Verification
REQ-030 Record 5 samples (sample_end with audio_in=0x0101..0x0105), stop_cmd -> 5 writes at addr 0..4, rec_len=5, state=IDLE.
REQ-031 Play after REQ-030, loop_en=0, 5 sample_req -> audio_out sequence 0x0101..0x0105, then state=IDLE, audio_out=0.
REQ-032 ADDR_W=3, 10 sample_end in RECORD -> 8 writes, full=1, rec_len=8, auto-return IDLE.
REQ-033 loop_en=1, rec_len=3, 7 sample_req -> audio_out 1,2,3,1,2,3,1.
REQ-034 stop_cmd and rec_cmd same cycle in PLAY -> IDLE; play_cmd with rec_len=0 -> stays IDLE.
REQ-035 reset asserted mid-RECORD after 3 writes -> next cycle rec_len=0, state=IDLE, no further mem_we.
